cardinal_nic: RTL and testbench

- Network interface controller between one processor (PE) and the pe port of its ring router.
- Holds one output-channel buffer (PE to router) and one input-channel buffer (router to PE), each a single 64-bit packet.
- The processor accesses both buffers and their status through four memory-mapped registers.
- Injection into the router is gated by the router's polarity bit, so packets enter only on their virtual-channel phase.

---
 rtl/cardinal_nic_pkg.sv | 24 ++
 rtl/nic_channel_buf.sv | 44 ++++
 rtl/cardinal_nic.sv | 93 +++++++++
 tb/tb_cardinal_nic.sv | 165 ++++++++++++++++
 4 files changed

// File: rtl/cardinal_nic_pkg.sv
// Shared constants for the cardinal NIC: register map and packet field positions.
package cardinal_nic_pkg;

  localparam int unsigned NIC_DATA_W = 64;
  localparam int unsigned NIC_ADDR_W = 2;

  localparam logic [NIC_ADDR_W-1:0] ADDR_IN_BUF   = 2'b00;
  localparam logic [NIC_ADDR_W-1:0] ADDR_IN_STAT  = 2'b01;
  localparam logic [NIC_ADDR_W-1:0] ADDR_OUT_BUF  = 2'b10;
  localparam logic [NIC_ADDR_W-1:0] ADDR_OUT_STAT = 2'b11;

  localparam int unsigned VC_BIT  = 63;
  localparam int unsigned DIR_BIT = 62;
  localparam int unsigned HOP_MSB = 55;
  localparam int unsigned HOP_LSB = 48;

  typedef enum logic { CH_EMPTY = 1'b0, CH_FULL = 1'b1 } ch_state_e;

  // Zero-extended status word returned on status register reads.
  function automatic logic [NIC_DATA_W-1:0] status_word(input logic flag);
    status_word = {{(NIC_DATA_W-1){1'b0}}, flag};
  endfunction

endpackage

// File: rtl/nic_channel_buf.sv
// One-entry packet buffer with EMPTY/FULL state; used for both NIC channels.
module nic_channel_buf
  import cardinal_nic_pkg::*;
#(
  parameter int unsigned W = 64
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load_i,
  input  logic [W-1:0] load_data_i,
  input  logic         unload_i,
  output logic         full_o,
  output logic [W-1:0] data_o
);

  ch_state_e    state_q;
  logic [W-1:0] data_q;

  // A load is only accepted into an empty slot; it wins over a same-cycle unload
  // so a capture into an empty buffer is never lost.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= CH_EMPTY;
      data_q  <= '0;
    end else begin
      case (state_q)
        CH_EMPTY: begin
          if (load_i) begin
            data_q  <= load_data_i;
            state_q <= CH_FULL;
          end
        end
        CH_FULL: begin
          if (unload_i) state_q <= CH_EMPTY;
        end
        default: state_q <= CH_EMPTY;
      endcase
    end
  end

  assign full_o = (state_q == CH_FULL);
  assign data_o = data_q;

endmodule

// File: rtl/cardinal_nic.sv
// Processor-to-ring-router network interface: one input and one output packet
// buffer behind four memory-mapped registers, injection gated by ring polarity.
module cardinal_nic
  import cardinal_nic_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 64,
  parameter int unsigned ADDR_WIDTH = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0] d_in,
  output logic [DATA_WIDTH-1:0] d_out,
  input  logic                  nicEn,
  input  logic                  nicWrEn,
  input  logic                  net_si,
  output logic                  net_ri,
  input  logic [DATA_WIDTH-1:0] net_di,
  output logic                  net_so,
  input  logic                  net_ro,
  output logic [DATA_WIDTH-1:0] net_do,
  input  logic                  net_polarity
);

  logic                  in_full, out_full;
  logic [DATA_WIDTH-1:0] in_buf, out_buf;
  logic                  rd_en, wr_en;
  logic                  in_load, in_unload, out_load, inject;

  logic [DATA_WIDTH-1:0] d_out_q, d_out_d;
  logic [DATA_WIDTH-1:0] net_do_q;
  logic                  net_so_q;

  assign rd_en = nicEn & ~nicWrEn;
  assign wr_en = nicEn &  nicWrEn;

  // net_ri is held low while full, so a router send never collides with a drain.
  assign in_load   = net_si & ~in_full;
  assign in_unload = rd_en & (addr == ADDR_IN_BUF);
  assign out_load  = wr_en & (addr == ADDR_OUT_BUF);
  assign inject    = out_full & net_ro & (out_buf[VC_BIT] == net_polarity);

  nic_channel_buf #(.W(DATA_WIDTH)) u_in_ch (
    .clk         (clk),
    .rst_n       (rst),
    .load_i      (in_load),
    .load_data_i (net_di),
    .unload_i    (in_unload),
    .full_o      (in_full),
    .data_o      (in_buf)
  );

  nic_channel_buf #(.W(DATA_WIDTH)) u_out_ch (
    .clk         (clk),
    .rst_n       (rst),
    .load_i      (out_load),
    .load_data_i (d_in),
    .unload_i    (inject),
    .full_o      (out_full),
    .data_o      (out_buf)
  );

  always_comb begin
    d_out_d = d_out_q;
    if (rd_en) begin
      case (addr)
        ADDR_IN_BUF:   d_out_d = in_buf;
        ADDR_IN_STAT:  d_out_d = status_word(in_full);
        ADDR_OUT_BUF:  d_out_d = '0;
        ADDR_OUT_STAT: d_out_d = status_word(out_full);
        default:       d_out_d = '0;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      d_out_q  <= '0;
      net_so_q <= 1'b0;
      net_do_q <= '0;
    end else begin
      d_out_q  <= d_out_d;
      net_so_q <= inject;
      if (inject) net_do_q <= out_buf;
    end
  end

  assign net_ri = ~in_full;
  assign d_out  = d_out_q;
  assign net_so = net_so_q;
  assign net_do = net_do_q;

endmodule

// File: tb/tb_cardinal_nic.sv
// Directed self-checking bench for cardinal_nic.
module tb_cardinal_nic;

  logic        clk, rst;
  logic [1:0]  addr;
  logic [63:0] d_in, d_out, net_di, net_do;
  logic        nicEn, nicWrEn, net_si, net_ri, net_so, net_ro, net_polarity;

  int errors = 0;
  int checks = 0;

  cardinal_nic dut (
    .clk(clk), .rst(rst), .addr(addr), .d_in(d_in), .d_out(d_out),
    .nicEn(nicEn), .nicWrEn(nicWrEn), .net_si(net_si), .net_ri(net_ri),
    .net_di(net_di), .net_so(net_so), .net_ro(net_ro), .net_do(net_do),
    .net_polarity(net_polarity)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic rd(input logic [1:0] a);
    addr = a; nicEn = 1'b1; nicWrEn = 1'b0;
    tick();
    nicEn = 1'b0;
  endtask

  task automatic wr(input logic [1:0] a, input logic [63:0] d);
    addr = a; d_in = d; nicEn = 1'b1; nicWrEn = 1'b1;
    tick();
    nicEn = 1'b0; nicWrEn = 1'b0;
  endtask

  initial begin
    rst = 1'b0; addr = 2'b00; d_in = '0; nicEn = 1'b0; nicWrEn = 1'b0;
    net_si = 1'b0; net_di = '0; net_ro = 1'b0; net_polarity = 1'b0;
    #1;
    chk("rst_d_out", d_out, 64'h0);
    chk("rst_net_so", {63'b0, net_so}, 64'h0);
    chk("rst_net_do", net_do, 64'h0);
    chk("rst_net_ri", {63'b0, net_ri}, 64'h1);
    tick(); tick();
    rst = 1'b1;
    tick();

    // Output path: vc=1 packet leaves only on the odd-phase edge.
    net_ro = 1'b1; net_polarity = 1'b0;
    wr(2'b10, 64'h8000_0000_0000_00AA);
    tick();
    chk("out_even_hold", {63'b0, net_so}, 64'h0);
    net_polarity = 1'b1;
    tick();
    chk("out_so_pulse", {63'b0, net_so}, 64'h1);
    chk("out_do", net_do, 64'h8000_0000_0000_00AA);
    net_polarity = 1'b0;
    tick();
    chk("out_so_single", {63'b0, net_so}, 64'h0);
    chk("out_do_hold", net_do, 64'h8000_0000_0000_00AA);
    rd(2'b11);
    chk("out_stat_empty", d_out, 64'h0);

    // Backpressure: vc=0 packet held while net_ro=0; second write dropped.
    net_ro = 1'b0;
    wr(2'b10, 64'h0000_0000_0000_0077);
    for (int i = 0; i < 5; i++) begin
      net_polarity = ~net_polarity;
      tick();
      chk("bp_no_send", {63'b0, net_so}, 64'h0);
    end
    rd(2'b11);
    chk("bp_stat_full", d_out, 64'h1);
    wr(2'b10, 64'h1);
    net_ro = 1'b1; net_polarity = 1'b0;
    tick();
    chk("bp_so", {63'b0, net_so}, 64'h1);
    chk("bp_do_orig", net_do, 64'h0000_0000_0000_0077);
    tick();
    chk("bp_so_once", {63'b0, net_so}, 64'h0);
    rd(2'b11);
    chk("bp_stat_after", d_out, 64'h0);
    chk("bp_no_resend", {63'b0, net_so}, 64'h0);

    // Input path and overflow.
    net_ro = 1'b0;
    net_si = 1'b1; net_di = 64'h4000_0000_0000_0055;
    tick();
    net_si = 1'b0; net_di = '0;
    chk("in_ri_low", {63'b0, net_ri}, 64'h0);
    rd(2'b01);
    chk("in_stat_full", d_out, 64'h1);
    net_si = 1'b1; net_di = 64'hDEAD;
    tick();
    net_si = 1'b0; net_di = '0;
    chk("in_ovf_ri", {63'b0, net_ri}, 64'h0);
    rd(2'b00);
    chk("in_read_data", d_out, 64'h4000_0000_0000_0055);
    chk("in_ri_back", {63'b0, net_ri}, 64'h1);
    rd(2'b01);
    chk("in_stat_empty", d_out, 64'h0);
    rd(2'b00);
    chk("in_stale_read", d_out, 64'h4000_0000_0000_0055);
    chk("in_stale_ri", {63'b0, net_ri}, 64'h1);
    rd(2'b10);
    chk("rd_outbuf_zero", d_out, 64'h0);

    // Write on the same edge as an injection is dropped.
    net_ro = 1'b1; net_polarity = 1'b0;
    wr(2'b10, 64'h8000_0000_0000_00BB);
    net_polarity = 1'b1;
    wr(2'b10, 64'h0000_0000_0000_00CC);
    chk("sim_so", {63'b0, net_so}, 64'h1);
    chk("sim_do", net_do, 64'h8000_0000_0000_00BB);
    net_polarity = 1'b0;
    tick();
    chk("sim_drop_even", {63'b0, net_so}, 64'h0);
    net_polarity = 1'b1;
    tick();
    chk("sim_drop_odd", {63'b0, net_so}, 64'h0);
    rd(2'b11);
    chk("sim_stat", d_out, 64'h0);

    // Asynchronous reset mid-operation with the output buffer full.
    net_ro = 1'b0;
    wr(2'b10, 64'h8000_0000_0000_00EE);
    net_si = 1'b1; net_di = 64'h123;
    tick();
    net_si = 1'b0;
    rd(2'b00);
    chk("pre_rst_d_out", d_out, 64'h123);
    #2 rst = 1'b0;
    #1;
    chk("arst_d_out", d_out, 64'h0);
    chk("arst_net_do", net_do, 64'h0);
    chk("arst_net_so", {63'b0, net_so}, 64'h0);
    chk("arst_net_ri", {63'b0, net_ri}, 64'h1);
    tick();
    rst = 1'b1;
    net_ro = 1'b1; net_polarity = 1'b1;
    tick();
    chk("post_rst_no_send", {63'b0, net_so}, 64'h0);
    rd(2'b11);
    chk("post_rst_out_stat", d_out, 64'h0);
    rd(2'b01);
    chk("post_rst_in_stat", d_out, 64'h0);
    rd(2'b00);
    chk("post_rst_in_buf", d_out, 64'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
